// File: rtl/gate_exerciser_if.sv
`default_nettype none
// ============================================================================
//  Module      : gate_exerciser_if
//  Description : Signal bundle between a gate exerciser and its environment.
//                Carries the run handshake, the gate drive/response pair and
//                the captured result.
//  Revision    : 1.0  initial release
// ============================================================================
interface gate_exerciser_if;
    logic       start;
    logic       gate_y;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] truth;
    logic [3:0] mismatch;

    // Environment side: requests runs and returns the gate response.
    modport master (
        output start,
        output gate_y,
        input  gate_a,
        input  gate_b,
        input  busy,
        input  done,
        input  pass,
        input  truth,
        input  mismatch
    );

    // Exerciser side: drives the gate and reports the result.
    modport slave (
        input  start,
        input  gate_y,
        output gate_a,
        output gate_b,
        output busy,
        output done,
        output pass,
        output truth,
        output mismatch
    );
endinterface : gate_exerciser_if
`default_nettype wire

// File: rtl/gate_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : gate_exerciser
//  Description : Walks a 2-input gate through all four input vectors, samples
//                its output after a settle window, captures a 4-bit truth
//                table and compares it against an expected table.
//  Revision    : 1.0  initial release
// ============================================================================
module gate_exerciser #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECTED      = 4'b0111
) (
    input  logic          clk,
    input  logic          rst,
    gate_exerciser_if.slave bus
);

    // Counter is wide enough to reach SETTLE_CYCLES itself, so the increment
    // on the last settle cycle can never wrap.
    localparam int                 c_cnt_w    = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_idx;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_gate_a;
    logic                 r_gate_b;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [3:0]           r_truth;

    state_t               w_state_next;
    logic [1:0]           w_idx_next;
    logic [1:0]           w_idx_inc;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic                 w_gate_a_next;
    logic                 w_gate_b_next;
    logic                 w_busy_next;
    logic                 w_done_next;
    logic                 w_pass_next;
    logic [3:0]           w_truth_next;
    logic [3:0]           w_truth_sample;

    // Next-state and next-output decode; every register defaults to holding.
    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_idx_inc      = r_idx + 2'd1;
        w_cnt_next     = r_cnt;
        w_gate_a_next  = r_gate_a;
        w_gate_b_next  = r_gate_b;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_pass_next    = r_pass;
        w_truth_next   = r_truth;
        w_truth_sample = r_truth;
        w_truth_sample[r_idx] = bus.gate_y;

        case (r_state)
            S_IDLE: begin
                w_gate_a_next = 1'b0;
                w_gate_b_next = 1'b0;
                w_busy_next   = 1'b0;
                if (bus.start) begin
                    w_state_next = S_SETTLE;
                    w_idx_next   = 2'd0;
                    w_cnt_next   = '0;
                    w_truth_next = 4'b0000;
                    w_pass_next  = 1'b0;
                    w_busy_next  = 1'b1;
                end
            end

            S_SETTLE: begin
                w_cnt_next = r_cnt + c_cnt_one;
                if (r_cnt == c_cnt_last) begin
                    w_state_next = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                w_truth_next = w_truth_sample;
                if (r_idx == 2'd3) begin
                    // Pass is judged on the table including this final sample.
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                    w_pass_next  = (w_truth_sample == EXPECTED);
                end else begin
                    // Next vector is applied on the same edge the sample lands.
                    w_state_next  = S_SETTLE;
                    w_idx_next    = w_idx_inc;
                    w_cnt_next    = '0;
                    w_gate_a_next = w_idx_inc[1];
                    w_gate_b_next = w_idx_inc[0];
                end
            end

            S_DONE: begin
                w_state_next  = S_IDLE;
                w_busy_next   = 1'b0;
                w_gate_a_next = 1'b0;
                w_gate_b_next = 1'b0;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run and clears the table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_cnt    <= '0;
            r_gate_a <= 1'b0;
            r_gate_b <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_truth  <= 4'b0000;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_cnt    <= w_cnt_next;
            r_gate_a <= w_gate_a_next;
            r_gate_b <= w_gate_b_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_pass   <= w_pass_next;
            r_truth  <= w_truth_next;
        end
    end

    assign bus.gate_a   = r_gate_a;
    assign bus.gate_b   = r_gate_b;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.truth    = r_truth;
    assign bus.mismatch = r_truth ^ EXPECTED;

endmodule : gate_exerciser
`default_nettype wire

// File: tb/tb_gate_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_exerciser
//  Description : Self-checking bench for gate_exerciser. A gate model feeds
//                gate_y; expected results are queued per run and compared
//                when done pulses. Second instance uses SETTLE_CYCLES=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gate_exerciser;

    localparam logic [3:0] c_expected = 4'b0111;

    typedef struct {
        logic [3:0] truth;
        logic       pass;
        logic [3:0] mism;
    } exp_t;

    logic clk;
    logic rst;
    logic start;
    logic sel;
    int   mode;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    logic       v_a, v_b, v_busy, v_done, v_pass;
    logic [3:0] v_truth, v_mism;

    gate_exerciser_if bus0 ();
    gate_exerciser_if bus1 ();

    gate_exerciser u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    gate_exerciser #(
        .SETTLE_CYCLES (1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Gate under test: 0 = NAND, 1 = AND, 2 = output stuck at 1.
    function automatic logic gate_model(input int m, input logic a, input logic b);
        case (m)
            1:       return a & b;
            2:       return 1'b1;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic [3:0] model_table(input int m);
        logic [3:0] t;
        logic [1:0] iv;
        for (int i = 0; i < 4; i++) begin
            iv   = 2'(i);
            t[i] = gate_model(m, iv[1], iv[0]);
        end
        return t;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model and start steering for both instances.
    always_comb begin
        bus0.start  = start & ~sel;
        bus1.start  = start & sel;
        bus0.gate_y = gate_model(mode, bus0.gate_a, bus0.gate_b);
        bus1.gate_y = gate_model(mode, bus1.gate_a, bus1.gate_b);
    end

    // View of whichever instance is currently exercised.
    always_comb begin
        v_a     = sel ? bus1.gate_a   : bus0.gate_a;
        v_b     = sel ? bus1.gate_b   : bus0.gate_b;
        v_busy  = sel ? bus1.busy     : bus0.busy;
        v_done  = sel ? bus1.done     : bus0.done;
        v_pass  = sel ? bus1.pass     : bus0.pass;
        v_truth = sel ? bus1.truth    : bus0.truth;
        v_mism  = sel ? bus1.mismatch : bus0.mismatch;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  32'(v_busy),  32'd0);
        check_eq({tag, "_done"},  32'(v_done),  32'd0);
        check_eq({tag, "_pass"},  32'(v_pass),  32'd0);
        check_eq({tag, "_truth"}, 32'(v_truth), 32'd0);
        check_eq({tag, "_ab"},    32'({v_a, v_b}), 32'd0);
        check_eq({tag, "_mism"},  32'(v_mism),  32'(c_expected));
    endtask

    // One exercise: start pulse (or held start for runs>1), optional ignored
    // restart pulse, optional mid-run reset. Cycle 1 follows the accept edge.
    task automatic do_run(input int settle, input int restart_at, input int rst_at, input int runs);
        int         latency;
        int         total;
        int         dones;
        int         j;
        int         pos;
        bit         in_run;
        int         exp_ab;
        exp_t       e;
        logic [3:0] t_exp;

        latency = 4 * (settle + 1) + 1;
        t_exp   = model_table(mode);
        if (rst_at == 0) begin
            for (int r = 0; r < runs; r++) begin
                e.truth = t_exp;
                e.pass  = (t_exp == c_expected);
                e.mism  = t_exp ^ c_expected;
                sb.push_back(e);
            end
        end
        total = (rst_at > 0) ? rst_at + 4 : runs * (latency + 1) + 2;
        dones = 0;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            start = (k <= (runs - 1) * (latency + 1)) || (k == restart_at);
            if (rst_at > 0 && k == rst_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                continue;
            end
            if (rst_at > 0 && k > rst_at) begin
                if (k == rst_at + 1) rst = 1'b0;
                check_eq("post_abort_busy", 32'(v_busy), 32'd0);
                check_eq("post_abort_done", 32'(v_done), 32'd0);
                if (v_done) dones++;
                continue;
            end
            j      = (k - 1) / (latency + 1);
            pos    = k - j * (latency + 1);
            in_run = (j < runs) && (pos <= latency);
            exp_ab = !in_run ? 0 : ((pos == latency) ? 3 : (pos - 1) / (settle + 1));
            check_eq("busy", 32'(v_busy), 32'(in_run));
            check_eq("done", 32'(v_done), 32'(in_run && pos == latency));
            check_eq("gate_ab", 32'({v_a, v_b}), 32'(exp_ab));
            if (v_done) begin
                dones++;
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("truth",    32'(v_truth), 32'(e.truth));
                    check_eq("pass",     32'(v_pass),  32'(e.pass));
                    check_eq("mismatch", 32'(v_mism),  32'(e.mism));
                end
            end
        end
        check_eq("done_count", 32'(dones), 32'((rst_at > 0) ? 0 : runs));
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        sel      = 1'b0;
        mode     = 0;

        repeat (3) @(negedge clk);
        check_all_zero("reset0");
        sel = 1'b1;
        #1;
        check_all_zero("reset1");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        mode = 0; do_run(2, 0, 0, 1);   // NAND: truth 0111, pass
        mode = 1; do_run(2, 0, 0, 1);   // AND: truth 1000, mismatch 1111
        mode = 2; do_run(2, 0, 0, 1);   // stuck-at-1: truth 1111, mismatch 1000
        mode = 0; do_run(2, 5, 0, 1);   // start while busy is ignored
        mode = 0; do_run(2, 0, 6, 1);   // reset mid-run aborts
        mode = 0; do_run(2, 0, 0, 1);   // clean run after abort
        mode = 0; do_run(2, 0, 0, 2);   // start held: back-to-back runs
        sel  = 1'b1;
        mode = 0; do_run(1, 0, 0, 1);   // SETTLE_CYCLES=1 instance
        mode = 1; do_run(1, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gate_exerciser
`default_nettype wire
